// File: rtl/pattern_sequencer_pkg.sv
// Shared definitions for the pattern sequencer: parameter defaults and
// the one-hot controller state encoding.
package pattern_sequencer_pkg;

    localparam int PAT_W_DEF = 16;
    localparam int CNT_W_DEF = 5;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_CLEAR = 5'b00010,
        ST_RUN   = 5'b00100,
        ST_DRAIN = 5'b01000,
        ST_DONE  = 5'b10000
    } state_t;

endpackage

// File: rtl/pattern_shifter.sv
// Pattern shift register plus bit-index counter; presents the current
// bit on bit_out (LSB first) and flags the last bit of the clamped length.
module pattern_shifter #(
    parameter int PAT_W = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] length,
    output logic             bit_out,
    output logic [CNT_W-1:0] idx,
    output logic             len_zero,
    output logic             last_bit
);

    localparam logic [CNT_W-1:0] PAT_W_C = CNT_W'(PAT_W);

    logic [PAT_W-1:0] sreg;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] len_clamped;

    assign len_clamped = (length > PAT_W_C) ? PAT_W_C : length;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg  <= '0;
            len_q <= '0;
            idx_q <= '0;
        end else if (load) begin
            sreg  <= pattern;
            len_q <= len_clamped;
            idx_q <= '0;
        end else if (shift) begin
            sreg  <= sreg >> 1;
            idx_q <= idx_q + CNT_W'(1);
        end
    end

    assign bit_out  = sreg[0];
    assign idx      = idx_q;
    assign len_zero = (len_q == '0);
    assign last_bit = (idx_q == len_q - CNT_W'(1));

endmodule

// File: rtl/pattern_sequencer.sv
// Plays a latched bit pattern into a sequence detector, resets the detector
// beforehand and tallies its z outputs per played bit.
module pattern_sequencer
    import pattern_sequencer_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] length,
    input  logic             z_in,
    output logic             w_out,
    output logic             det_reset,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] first_idx,
    output logic [4:0]       state
);

    state_t cur_st, nxt_st;

    logic             load;
    logic             shift;
    logic             bit_out;
    logic [CNT_W-1:0] idx;
    logic             len_zero;
    logic             last_bit;
    logic             sample;
    logic             found;
    logic [CNT_W-1:0] attr_idx;

    pattern_shifter #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) u_shifter (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift    (shift),
        .pattern  (pattern),
        .length   (length),
        .bit_out  (bit_out),
        .idx      (idx),
        .len_zero (len_zero),
        .last_bit (last_bit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cur_st <= ST_IDLE;
        else        cur_st <= nxt_st;
    end

    always_comb begin
        nxt_st = cur_st;
        load   = 1'b0;
        shift  = 1'b0;
        unique case (cur_st)
            ST_IDLE: begin
                if (start && !abort) begin
                    nxt_st = ST_CLEAR;
                    load   = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (abort)         nxt_st = ST_IDLE;
                else if (len_zero) nxt_st = ST_DONE;
                else               nxt_st = ST_RUN;
            end
            ST_RUN: begin
                shift = 1'b1;
                if (abort)         nxt_st = ST_IDLE;
                else if (last_bit) nxt_st = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (abort) nxt_st = ST_IDLE;
                else       nxt_st = ST_DONE;
            end
            ST_DONE:  nxt_st = ST_IDLE;
            default:  nxt_st = ST_IDLE;
        endcase
    end

    // z reflects the bit played one cycle earlier; the index has already
    // advanced past it in both RUN and DRAIN, so the attributed bit is idx-1.
    assign sample   = !abort && ((cur_st == ST_RUN && idx != '0) || cur_st == ST_DRAIN);
    assign attr_idx = idx - CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_count <= '0;
            first_idx   <= '1;
            found       <= 1'b0;
        end else if (load) begin
            match_count <= '0;
            first_idx   <= '1;
            found       <= 1'b0;
        end else if (sample && z_in) begin
            match_count <= match_count + CNT_W'(1);
            if (!found) begin
                first_idx <= attr_idx;
                found     <= 1'b1;
            end
        end
    end

    assign w_out     = (cur_st == ST_RUN) && bit_out;
    assign det_reset = reset && (cur_st != ST_CLEAR);
    assign busy      = (cur_st == ST_CLEAR) || (cur_st == ST_RUN) || (cur_st == ST_DRAIN);
    assign done      = (cur_st == ST_DONE);
    assign state     = cur_st;

endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 SHALL have parameter PAT_W, default 16, maximum pattern length in bits.
REQ-002 SHALL have parameter CNT_W, default 5, width of the match counter and index outputs.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  begin a run; sampled in IDLE only.
REQ-006 SHALL have port abort  input  1  cancel the current run.
REQ-007 SHALL have port pattern  input  PAT_W  bits to play, LSB first; latched on accepted start.
REQ-008 SHALL have port length  input  CNT_W  number of bits to play, 0..PAT_W; latched on accepted start.
REQ-009 SHALL have port z_in  input  1  match output from the sequence-detector FSM under test.
REQ-010 SHALL have port w_out  output  1  serial bit driven to the detector's w input.
REQ-011 SHALL have port det_reset  output  1  active-low reset to the detector.
REQ-012 SHALL have port busy  output  1  high in CLEAR, RUN and DRAIN.
REQ-013 SHALL have port done  output  1  one-cycle pulse at normal run completion.
REQ-014 SHALL have port match_count  output  CNT_W  number of sampled z_in highs in the run.
REQ-015 SHALL have port first_idx  output  CNT_W  bit index of the first match; all-ones if none.
REQ-016 SHALL have port state  output  5  one-hot state {DONE,DRAIN,RUN,CLEAR,IDLE}, MSB..LSB.

Function
REQ-017 SHALL use five one-hot states: IDLE, CLEAR, RUN, DRAIN, DONE.
REQ-018 SHALL transition IDLE->CLEAR when start=1 and abort=0; otherwise remain in IDLE.
REQ-019 SHALL, on accepted start, latch pattern and length, clear match_count to 0, and set first_idx to all-ones.
REQ-020 SHALL hold det_reset=0 for exactly the one CLEAR cycle and 1 in all other states.
REQ-021 SHALL go CLEAR->RUN if latched length>0, else CLEAR->DONE.
REQ-022 SHALL, in RUN cycle i (i=0..length-1), drive w_out=pattern[i]; RUN->DRAIN after cycle length-1.
REQ-023 SHALL drive w_out=0 in every state other than RUN.
REQ-024 SHALL sample z_in in RUN cycles 1..length-1 and in the single DRAIN cycle, attributing each sample to bit i-1 (DRAIN: bit length-1).
REQ-025 SHALL increment match_count on each z_in=1 sample and SHALL NOT sample z_in in IDLE, CLEAR or DONE.
REQ-026 SHALL load first_idx with the attributed bit index on the first z_in=1 sample of a run only.
REQ-027 SHALL go DRAIN->DONE, assert done=1 for the single DONE cycle, then go DONE->IDLE.
REQ-028 SHALL, when abort=1 in CLEAR, RUN or DRAIN, go to IDLE next cycle with no done pulse, holding match_count and first_idx.
REQ-029 SHALL ignore start outside IDLE; abort in IDLE or DONE SHALL have no effect.
REQ-030 SHALL treat length>PAT_W as PAT_W.
REQ-031 SHALL hold match_count and first_idx stable from DONE until the next accepted start.

Reset
REQ-032 SHALL, while reset=0, immediately force state=IDLE, w_out=0, det_reset=0, busy=0, done=0, match_count=0, first_idx=all-ones.
REQ-033 SHALL abandon any run in progress when reset is asserted mid-run, and SHALL resume in IDLE after reset deasserts.

Structure
REQ-034 SHALL place the state one-hot encodings and the PAT_W and CNT_W defaults in a shared package.
REQ-035 SHALL split the pattern shift register and bit-index counter into one sub-module, pattern_shifter, with the FSM and match logic kept in the top.

Verification
REQ-036 SHALL cover pattern=16'h0003, length=4 -> bits 1,1,0,0; match_count=2, first_idx=1, done at cycle 7 after start.
REQ-037 SHALL cover pattern=16'h0005, length=4 -> bits 1,0,1,0; match_count=0, first_idx=5'h1F.
REQ-038 SHALL cover pattern=16'hFFFF, length=16 -> match_count=15, first_idx=1, busy for 18 cycles.
REQ-039 SHALL cover length=0 -> CLEAR, then DONE with done=1, match_count=0, w_out=0 throughout.
REQ-040 SHALL cover abort in RUN cycle 2 -> IDLE next cycle, no done pulse, and a start held during the run ignored.
REQ-041 SHALL cover reset=0 asserted mid-RUN -> all outputs at reset values before the next clk edge.
